// File: rtl/light_bar_monitor.sv
// Receive-side checker for a thermometer-coded light bar: decode, step check, lock FSM.
// Optional err_count output enabled by defining LIGHT_BAR_ERRCNT_EN.
module light_bar_monitor #(
    parameter  int WIDTH = 3,
    parameter  int CNT_W = 8,
    localparam int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bar_in,
    input  logic             bar_valid,
    output logic [LW-1:0]    level,
    output logic             level_valid,
    output logic             code_err,
    output logic             seq_err,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] cycle_count,
`ifdef LIGHT_BAR_ERRCNT_EN
    output logic [CNT_W-1:0] err_count,
`endif
    output logic             locked
);

    typedef enum logic [1:0] {ACQUIRE, TRACK, FAULT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sample;
    logic               r_sample_vld;
    logic [LW-1:0]      r_level;
    logic               r_level_valid;
    logic               r_code_err;
    logic               r_seq_err;
    logic               r_wrap;
    logic [CNT_W-1:0]   r_cycle_cnt;

    logic               w_legal;
    logic [LW-1:0]      w_n;
    logic               w_step_ok;
    logic               w_wrap_step;
    logic [LW-1:0]      w_level_nxt;
    logic               w_lv_nxt;
    logic               w_ce_nxt;
    logic               w_se_nxt;
    logic               w_wrap_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
        end else begin
            r_sample_vld <= bar_valid;
            if (bar_valid)
                r_sample <= bar_in;
        end
    end

    // A thermometer code plus one is a power of two (all-ones wraps to zero).
    assign w_legal = ((r_sample + WIDTH'(1)) & r_sample) == '0;

    always_comb begin
        w_n = '0;
        for (int i = 0; i < WIDTH; i++)
            w_n = w_n + LW'(r_sample[i]);
    end

    assign w_step_ok   = (w_n == r_level) ||
                         ({1'b0, w_n} == ({1'b0, r_level} + (LW + 1)'(1)));
    assign w_wrap_step = (r_level == LW'(WIDTH)) && (w_n == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ACQUIRE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_sample_vld) begin
            unique case (r_state)
                ACQUIRE: if (w_legal) w_state_nxt = TRACK;
                TRACK: begin
                    if (!w_legal || !(w_step_ok || w_wrap_step))
                        w_state_nxt = FAULT;
                end
                FAULT: if (w_legal && w_n == '0) w_state_nxt = TRACK;
                default: w_state_nxt = ACQUIRE;
            endcase
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        w_lv_nxt    = 1'b0;
        w_ce_nxt    = 1'b0;
        w_se_nxt    = 1'b0;
        w_wrap_nxt  = 1'b0;
        w_cnt_nxt   = r_cycle_cnt;
        if (r_sample_vld) begin
            if (!w_legal) begin
                w_ce_nxt = 1'b1;
            end else begin
                w_lv_nxt    = 1'b1;
                w_level_nxt = w_n;
                if (r_state == TRACK) begin
                    if (w_wrap_step) begin
                        w_wrap_nxt = 1'b1;
                        if (r_cycle_cnt != '1)
                            w_cnt_nxt = r_cycle_cnt + CNT_W'(1);
                    end else if (!w_step_ok) begin
                        w_se_nxt = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level       <= '0;
            r_level_valid <= 1'b0;
            r_code_err    <= 1'b0;
            r_seq_err     <= 1'b0;
            r_wrap        <= 1'b0;
            r_cycle_cnt   <= '0;
        end else begin
            r_level       <= w_level_nxt;
            r_level_valid <= w_lv_nxt;
            r_code_err    <= w_ce_nxt;
            r_seq_err     <= w_se_nxt;
            r_wrap        <= w_wrap_nxt;
            r_cycle_cnt   <= w_cnt_nxt;
        end
    end

`ifdef LIGHT_BAR_ERRCNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_err_cnt <= '0;
        else if ((w_ce_nxt || w_se_nxt) && r_err_cnt != '1)
            r_err_cnt <= r_err_cnt + CNT_W'(1);
    end

    assign err_count = r_err_cnt;
`endif

    assign level       = r_level;
    assign level_valid = r_level_valid;
    assign code_err    = r_code_err;
    assign seq_err     = r_seq_err;
    assign wrap_pulse  = r_wrap;
    assign cycle_count = r_cycle_cnt;
    assign locked      = (r_state == TRACK);

endmodule

// File: doc/light_bar_monitor.md
Name: light_bar_monitor

Overview:
Receive-side checker for the thermometer-coded light-bar sequence 000 -> 001 -> 011 -> 111 -> 000. It samples the bar, decodes it to a level count and flags illegal codes and illegal steps. It also counts completed wrap cycles and reports lock status. It sits at the consumer end of the light-bar sequencer and feeds status and debug logic.

Parameters:
WIDTH, 3, number of bar segments (thermometer bits); must be >= 2
CNT_W, 8, width of the completed-cycle counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
bar_in  input  WIDTH  thermometer-coded bar from the sequencer
bar_valid  input  1  bar_in is sampled only when high
level  output  $clog2(WIDTH+1)  decoded count of lit segments
level_valid  output  1  one-cycle pulse; level updated from a legal code
code_err  output  1  one-cycle pulse; sampled code is not a thermometer code
seq_err  output  1  one-cycle pulse; legal code but illegal step
wrap_pulse  output  1  one-cycle pulse on a WIDTH -> 0 transition while tracking
cycle_count  output  CNT_W  saturating count of wrap_pulse events
locked  output  1  high while the FSM is in TRACK

Behaviour:
- Reset, asynchronous and active-high, sets:
  - level=0, all pulse outputs=0, cycle_count=0, locked=0
  - sample register=0, sample-valid flag=0, FSM=ACQUIRE
- Pipeline: when bar_valid=1 at edge k, bar_in is captured in the sample register. All outputs reflect that sample after edge k+1 (latency 2 clocks).
- bar_valid=0 at edge k: no sample. At edge k+1 all pulses are 0; level, cycle_count and FSM hold.
- Legal code: bits [L-1:0]=1 and the rest 0, for L in 0..WIDTH. Its decoded level is L.
- Any other pattern is illegal (e.g. 010, 101, 100 for WIDTH=3):
  - code_err pulses; level holds; seq_err not evaluated.
- Legal steps from previous level P to new level N:
  - N==P (stall/repeat)
  - N==P+1
  - P==WIDTH and N==0 (wrap)
  - All other N are illegal steps.
- FSM:
  - ACQUIRE:
    - legal code: load level, pulse level_valid, go to TRACK; no step check, no wrap_pulse.
    - illegal code: pulse code_err, stay.
  - TRACK:
    - legal step: update level, pulse level_valid.
    - wrap step: additionally pulse wrap_pulse and increment cycle_count, saturating at 2^CNT_W-1.
    - illegal code: pulse code_err, go to FAULT.
    - legal code with illegal step: pulse seq_err and level_valid, load level, go to FAULT.
  - FAULT:
    - legal code with N==0: load level, pulse level_valid, go to TRACK.
    - other legal code: load level, pulse level_valid, stay (no seq_err re-flag).
    - illegal code: pulse code_err, stay.
- code_err and seq_err never assert in the same cycle.
- level_valid and code_err never assert in the same cycle.
- Reset asserted mid-sequence takes effect immediately and forces the full reset state. The first sample after reset release goes through ACQUIRE.

Optional Feature:
LIGHT_BAR_ERRCNT_EN
- Defined:
  - Adds output port err_count, width CNT_W.
  - Increments by 1 in any cycle where code_err or seq_err pulses; saturates at 2^CNT_W-1.
  - Reset to 0 by reset.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then bar_valid=1 with bar_in 000,001,011,111,000,001 on consecutive cycles:
  - level 0,1,2,3,0,1, each 2 clocks after its sample; level_valid every cycle.
  - locked=1 from the first output; one wrap_pulse; cycle_count=1; no errors.
- In TRACK at level 1, drive 010:
  - code_err pulses once; level stays 1; locked drops.
  - Then 000 -> level 0, locked=1 again.
- In TRACK at level 1, drive 111:
  - seq_err pulses, level=3, locked=0.
  - Next 011 -> no error, still FAULT; then 000 -> locked=1.
- Interleave bar_valid=0 cycles and repeated codes (001,001,001,011):
  - no errors; level holds through gaps; level_valid only on valid samples.
- CNT_W=2, run 5 full cycles -> cycle_count saturates at 3; wrap_pulse fires 5 times.
- Assert reset mid-sequence at level 2:
  - all outputs 0 asynchronously.
  - After release, first sample 011 -> level 2, locked=1, no seq_err.
  - With LIGHT_BAR_ERRCNT_EN, err_count is 0 after reset.
